// File: rtl/riscv_pipe_pkg.sv
// Purpose: shared types and constants for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pipe_pkg;

    // Default register-index width for a 32-entry register file.
    localparam int ADDR_W_DEF = 5;

    // Register x0 is hard-wired to zero, so writes to it never create a hazard.
    localparam int REG_ZERO = 0;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hsc_state_e;

endpackage : riscv_pipe_pkg

// File: rtl/hazard_stall_controller_sat_counter.sv
// Purpose: saturating up-counter with synchronous clear (clear beats increment).
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc, clr -> q[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_stall_controller.sv
// Purpose: pipeline hazard/stall/flush sequencing (load-use, branch flush, MDU freeze + watchdog).
// Latency: enables/flushes are combinational from state and inputs; state, counters, flag registered.
// Backpressure: freezes PC/IF/ID/ID/EX while the MDU runs; one bubble per load-use hazard.
// Ports: ID/EX hazard inputs, branch/MDU status, perf_clr -> stage enables, flushes,
//        mdu_start pulse, sticky mdu_timeout, stall_cnt / flush_cnt perf counters.
module hazard_stall_controller
    import riscv_pipe_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CNT_W       = 16,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ex_mdu_valid,
    input  logic              mdu_done,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              mdu_start,
    output logic              mdu_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                WD_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(MDU_TIMEOUT - 1);

    hsc_state_e      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            mdu_timeout_q, mdu_timeout_d;

    logic load_use;
    logic wd_hit;
    logic timeout_ev;
    logic flush_ev;
    logic pc_en_c, ifid_en_c, idex_en_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c, mdu_start_c;

    // Forwarding cannot cover a load result needed in the very next cycle.
    assign load_use = ex_mem_read && (ex_rd != ADDR_W'(REG_ZERO)) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    // Watchdog value equals the number of busy cycles already spent.
    assign wd_hit = (wd_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        timeout_ev    = 1'b0;
        flush_ev      = 1'b0;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        mdu_start_c   = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    // A load-use seen now belongs to the wrong path; just flush.
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                    flush_ev     = 1'b1;
                end else if (ex_mdu_valid) begin
                    mdu_start_c   = 1'b1;
                    pc_en_c       = 1'b0;
                    ifid_en_c     = 1'b0;
                    idex_en_c     = 1'b0;
                    exmem_flush_c = 1'b1;
                    wd_d          = '0;
                    state_d       = MDU_BUSY;
                end else if (load_use) begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (mdu_done || wd_hit) begin
                    // Release: EX/MEM captures the MDU result this cycle.
                    timeout_ev = wd_hit;
                    state_d    = RUN;
                end else begin
                    pc_en_c       = 1'b0;
                    ifid_en_c     = 1'b0;
                    idex_en_c     = 1'b0;
                    exmem_flush_c = 1'b1;
                    wd_d          = wd_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        mdu_timeout_d = perf_clr ? 1'b0 : (mdu_timeout_q | timeout_ev);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wd_q          <= '0;
            mdu_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            mdu_timeout_q <= mdu_timeout_d;
        end
    end

    // Reset holds the pipe frozen and fully flushed regardless of inputs.
    assign pc_en       = rst_n & pc_en_c;
    assign ifid_en     = rst_n & ifid_en_c;
    assign idex_en     = rst_n & idex_en_c;
    assign ifid_flush  = ~rst_n | ifid_flush_c;
    assign idex_flush  = ~rst_n | idex_flush_c;
    assign exmem_flush = ~rst_n | exmem_flush_c;
    assign mdu_start   = rst_n & mdu_start_c;
    assign mdu_timeout = mdu_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_en_c),
        .clr   (perf_clr),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_ev),
        .clr   (perf_clr),
        .q     (flush_cnt)
    );

endmodule : hazard_stall_controller

// File: tb/tb_hazard_stall_controller.sv
// Purpose: self-checking bench for hazard_stall_controller (directed + random vs. reference model).
// Latency: model compares combinational outputs mid-cycle and registered counters each cycle.
// Backpressure: n/a.
module tb_hazard_stall_controller;

    localparam int ADDR_W = 5;
    localparam int TMO    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2;
    logic              ex_mem_read, ex_branch_taken, ex_mdu_valid, mdu_done, perf_clr;

    logic        m_pc_en, m_ifid_en, m_idex_en, m_ifid_flush, m_idex_flush, m_exmem_flush;
    logic        m_mdu_start, m_mdu_timeout;
    logic [15:0] m_stall_cnt, m_flush_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_ifid_flush, s_idex_flush, s_exmem_flush;
    logic        s_mdu_start, s_mdu_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    hazard_stall_controller #(.ADDR_W(ADDR_W), .CNT_W(16), .MDU_TIMEOUT(TMO)) u_main (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_valid(ex_mdu_valid), .mdu_done(mdu_done), .perf_clr(perf_clr),
        .pc_en(m_pc_en), .ifid_en(m_ifid_en), .idex_en(m_idex_en),
        .ifid_flush(m_ifid_flush), .idex_flush(m_idex_flush), .exmem_flush(m_exmem_flush),
        .mdu_start(m_mdu_start), .mdu_timeout(m_mdu_timeout),
        .stall_cnt(m_stall_cnt), .flush_cnt(m_flush_cnt)
    );

    hazard_stall_controller #(.ADDR_W(ADDR_W), .CNT_W(2), .MDU_TIMEOUT(TMO)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_valid(ex_mdu_valid), .mdu_done(mdu_done), .perf_clr(perf_clr),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .mdu_start(s_mdu_start), .mdu_timeout(s_mdu_timeout),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: pipeline mode plus unbounded event counts.
    bit m_busy;
    int m_bcnt;
    int m_stall;
    int m_flush;
    bit m_to;
    int mon_frozen = 0;
    int mon_start  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare every DUT output against the model, then advance the model one cycle.
    task automatic model_check();
        logic [6:0] e7;
        bit ld, rel, to_ev, flush_ev;
        logic [7:0] om, os;
        om = {m_pc_en, m_ifid_en, m_idex_en, m_ifid_flush, m_idex_flush,
              m_exmem_flush, m_mdu_start, m_mdu_timeout};
        os = {s_pc_en, s_ifid_en, s_idex_en, s_ifid_flush, s_idex_flush,
              s_exmem_flush, s_mdu_start, s_mdu_timeout};
        if (!rst_n) begin
            m_busy = 0; m_bcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
            chk("reset_outs_main", 32'(om), 32'(8'b0001_1100));
            chk("reset_outs_sat",  32'(os), 32'(8'b0001_1100));
            chk("reset_stall_main", 32'(m_stall_cnt), 0);
            chk("reset_flush_main", 32'(m_flush_cnt), 0);
            chk("reset_stall_sat",  32'(s_stall_cnt), 0);
            chk("reset_flush_sat",  32'(s_flush_cnt), 0);
            return;
        end
        ld = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        to_ev = 0; flush_ev = 0; rel = 0;
        // bit order: pc ifid idex ifid_fl idex_fl exmem_fl start
        if (m_busy) begin
            to_ev = (m_bcnt + 1 == TMO);
            rel   = mdu_done || to_ev;
            e7    = rel ? 7'b111_0000 : 7'b000_0010;
        end else if (ex_branch_taken) begin
            e7 = 7'b111_1100; flush_ev = 1;
        end else if (ex_mdu_valid) begin
            e7 = 7'b000_0011;
        end else if (ld) begin
            e7 = 7'b001_0100;
        end else begin
            e7 = 7'b111_0000;
        end
        chk("outs_main",  32'(om), 32'({e7, m_to}));
        chk("outs_sat",   32'(os), 32'({e7, m_to}));
        chk("stall_main", 32'(m_stall_cnt), 32'(sat(m_stall, 65535)));
        chk("stall_sat",  32'(s_stall_cnt), 32'(sat(m_stall, 3)));
        chk("flush_main", 32'(m_flush_cnt), 32'(sat(m_flush, 65535)));
        chk("flush_sat",  32'(s_flush_cnt), 32'(sat(m_flush, 3)));
        if (!m_pc_en)    mon_frozen++;
        if (m_mdu_start) mon_start++;
        if (!e7[6])   m_stall++;
        if (flush_ev) m_flush++;
        if (to_ev)    m_to = 1;
        if (perf_clr) begin m_stall = 0; m_flush = 0; m_to = 0; end
        if (m_busy) begin
            if (rel) m_busy = 0; else m_bcnt++;
        end else if (!ex_branch_taken && ex_mdu_valid) begin
            m_busy = 1; m_bcnt = 0;
        end
    endtask

    // One cycle: check at the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_valid = 0; mdu_done = 0; perf_clr = 0;
    endtask

    task automatic load_use_rs2();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    endtask

    task automatic clear_perf();
        idle(); perf_clr = 1; tick(); idle();
    endtask

    initial begin
        int f0, s0;
        rst_n = 0;
        idle();
        tick(); tick();
        rst_n = 1;
        tick();

        // Load-use on rs2: exactly one frozen cycle.
        f0 = mon_frozen;
        load_use_rs2(); tick(); idle();
        chk("lu_stall_cnt", 32'(m_stall_cnt), 1);
        chk("lu_frozen", 32'(mon_frozen - f0), 1);
        tick();

        // x0 destination and unused source never stall.
        clear_perf();
        chk("clr_stall_cnt", 32'(m_stall_cnt), 0);
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; tick();
        idle(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
        id_rs2 = 3; id_use_rs2 = 1; tick();
        idle();
        chk("nostall_cnt", 32'(m_stall_cnt), 0);

        // Branch wins over a simultaneous load-use.
        load_use_rs2(); ex_branch_taken = 1; tick(); idle();
        chk("br_flush_cnt", 32'(m_flush_cnt), 1);
        chk("br_stall_cnt", 32'(m_stall_cnt), 0);

        // MDU op done after 4 busy cycles; branch in the window ignored.
        clear_perf();
        f0 = mon_frozen; s0 = mon_start;
        ex_mdu_valid = 1; tick(); idle();
        for (int i = 1; i <= 4; i++) begin
            ex_branch_taken = (i == 2); tick(); idle();
        end
        mdu_done = 1; tick(); idle();
        chk("mdu_start_pulses", 32'(mon_start - s0), 1);
        chk("mdu_frozen", 32'(mon_frozen - f0), 5);
        chk("mdu_stall_cnt", 32'(m_stall_cnt), 5);
        chk("mdu_flush_cnt", 32'(m_flush_cnt), 0);
        tick();

        // Watchdog: no done at all.
        clear_perf();
        f0 = mon_frozen;
        ex_mdu_valid = 1; tick(); idle();
        for (int i = 0; i < 10; i++) tick();
        chk("wd_frozen", 32'(mon_frozen - f0), 8);
        chk("wd_flag", 32'(m_mdu_timeout), 1);
        chk("wd_stall_cnt", 32'(m_stall_cnt), 8);
        clear_perf();
        chk("wd_flag_clr", 32'(m_mdu_timeout), 0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            load_use_rs2(); tick(); idle(); tick();
        end
        chk("sat_stall_cnt", 32'(s_stall_cnt), 3);
        chk("wide_stall_cnt", 32'(m_stall_cnt), 5);

        // Reset in the middle of an MDU op.
        ex_mdu_valid = 1; tick(); idle();
        tick(); tick();
        rst_n = 0; #1;
        chk("rst_mid_stall", 32'(m_stall_cnt), 0);
        chk("rst_mid_pc_en", 32'(m_pc_en), 0);
        tick();
        rst_n = 1; #1;
        chk("rst_exit_pc_en", 32'(m_pc_en), 1);
        chk("rst_exit_start", 32'(m_mdu_start), 0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            id_rs1          = ADDR_W'($urandom_range(0, 7));
            id_rs2          = ADDR_W'($urandom_range(0, 7));
            ex_rd           = ADDR_W'($urandom_range(0, 7));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            ex_mdu_valid    = ($urandom_range(0, 99) < 10);
            mdu_done        = ($urandom_range(0, 99) < 15);
            perf_clr        = ($urandom_range(0, 99) < 3);
            tick();
        end
        rst_n = 1; idle(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_hazard_stall_controller
